flt_recip_pack: RTL and testbench

Output stage of the single-precision reciprocal datapath, directly downstream of the GTP_APM_E2 multiplier that produces the final Newton-iteration product.
- Delays each issued operand's side-band (sign, exponent, class) so it lines up with the 48-bit product P.
- Normalises, rounds RNE and packs an IEEE-754 result, handling special classes.
- Queues results in an output FIFO behind a valid/ready interface, with credit-based issue back-pressure.

---
 rtl/recip_pkg.sv | 37 +++
 rtl/recip_out_fifo.sv | 72 +++++++
 rtl/flt_recip_pack.sv | 196 +++++++++++++++++++
 tb/tb_flt_recip_pack.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/recip_pkg.sv
// -----------------------------------------------------------------------------
// recip_pkg
// Shared constants and types for the single-precision reciprocal output stage:
// operand class encodings, IEEE-754 constants, result flag bit positions, the
// side-band record that travels with each issued operand, and the packed
// result record stored in the output FIFO.
// -----------------------------------------------------------------------------
package recip_pkg;

  // Operand class encodings (iss_cls)
  localparam logic [1:0] CLS_NORM = 2'd0;
  localparam logic [1:0] CLS_ZERO = 2'd1;  // zero or subnormal input
  localparam logic [1:0] CLS_INF  = 2'd2;
  localparam logic [1:0] CLS_NAN  = 2'd3;

  localparam int          F32_BIAS = 127;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;

  // Bit positions inside the 3-bit flag word {dz, uf, nx}
  localparam int FLG_DZ = 2;
  localparam int FLG_UF = 1;
  localparam int FLG_NX = 0;

  // Per-operand side-band, delayed to line up with the multiplier product
  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [1:0] cls;
  } sband_t;

  // One packed result as queued in the output FIFO
  typedef struct packed {
    logic [2:0]  flags;
    logic [31:0] data;
  } res_t;

endpackage

// File: rtl/recip_out_fifo.sv
// -----------------------------------------------------------------------------
// recip_out_fifo
// Order-preserving, first-word fall-through synchronous FIFO with occupancy
// output. The head entry is visible on dout_o whenever count_o is non-zero;
// dout_o reads as zero while empty (and therefore while in reset).
//
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset (pointers and count only)
//   push_i   in   write din_i at the tail this cycle
//   din_i    in   WIDTH-bit entry to write
//   pop_i    in   drop the head entry this cycle (only while non-empty)
//   dout_o   out  head entry
//   count_o  out  number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module recip_out_fifo #(
  parameter int DEPTH = 4,   // power of two, >= 2
  parameter int WIDTH = 35
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_i) wr_d = wr_q + 1'b1;
    if (pop_i)  rd_d = rd_q + 1'b1;
    cnt_d = cnt_q + {{AW{1'b0}}, push_i} - {{AW{1'b0}}, pop_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= din_i;
  end

  assign dout_o  = (cnt_q != '0) ? mem_q[rd_q] : '0;
  assign count_o = cnt_q;

  // Upstream credit accounting must never let the FIFO overflow.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && !pop_i && (cnt_q == (AW+1)'(DEPTH))));

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop_i && (cnt_q == '0)));

endmodule

// File: rtl/flt_recip_pack.sv
// -----------------------------------------------------------------------------
// flt_recip_pack
// Output stage of the single-precision reciprocal datapath. Each issued
// operand's side-band (sign, exponent, class) is delayed MULT_LAT cycles so it
// meets the multiplier product P; both are captured in the round register, then
// normalised, rounded to nearest-even and packed into an IEEE-754 result that
// is queued in a FWFT output FIFO behind a valid/ready interface. Issue is
// throttled by a credit count covering queued plus in-flight results.
//
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   iss_vld    in   operand issued to the multiplier this cycle
//   iss_rdy    out  one more result can be absorbed (registered)
//   iss_sign   in   operand sign
//   iss_exp    in   operand biased exponent
//   iss_cls    in   operand class (NORM/ZERO/INF/NAN)
//   mul_p      in   48-bit product, reciprocal mantissa r = P / 2^46
//   out_vld    out  result available at the FIFO head
//   out_rdy    in   consumer accepts the head result
//   out_data   out  packed float result
//   out_flags  out  {dz, uf, nx}
// -----------------------------------------------------------------------------
module flt_recip_pack
  import recip_pkg::*;
#(
  parameter int MULT_LAT   = 2,  // 0..4
  parameter int FIFO_DEPTH = 4   // power of two, >= 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        iss_vld,
  output logic        iss_rdy,
  input  logic        iss_sign,
  input  logic [7:0]  iss_exp,
  input  logic [1:0]  iss_cls,
  input  logic [47:0] mul_p,
  output logic        out_vld,
  input  logic        out_rdy,
  output logic [31:0] out_data,
  output logic [2:0]  out_flags
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic signed [9:0] E_HI = 10'(2 * F32_BIAS);  // exponent when P[46]=1

  // Normalise, round to nearest-even and pack one result.
  function automatic res_t pack_result(input sband_t sb, input logic [46:0] p);
    res_t               r;
    logic [22:0]        man;
    logic               g;
    logic               s;
    logic signed [9:0]  e;
    logic [23:0]        man_r;
    r     = '0;
    man   = '0;
    g     = 1'b0;
    s     = 1'b0;
    e     = '0;
    man_r = '0;
    case (sb.cls)
      CLS_ZERO: begin
        r.data          = {sb.sign, 8'hFF, 23'b0};
        r.flags[FLG_DZ] = 1'b1;
      end
      CLS_INF:  r.data = {sb.sign, 31'b0};
      CLS_NAN:  r.data = QNAN;
      default: begin
        // r in (0.5,1]: leading one is P[46] only for r == 1.0
        if (p[46]) begin
          man = p[45:23];
          g   = p[22];
          s   = |p[21:0];
          e   = E_HI - $signed({2'b00, sb.exp});
        end else begin
          man = p[44:22];
          g   = p[21];
          s   = |p[20:0];
          e   = E_HI - 10'sd1 - $signed({2'b00, sb.exp});
        end
        if (e <= 10'sd0) begin
          // No subnormal outputs: flush to signed zero
          r.data          = {sb.sign, 31'b0};
          r.flags[FLG_UF] = 1'b1;
          r.flags[FLG_NX] = 1'b1;
        end else begin
          man_r = {1'b0, man} + {23'b0, g & (s | man[0])};
          // Mantissa carry leaves man_r[22:0] == 0; bump the exponent
          if (man_r[23]) e = e + 10'sd1;
          r.data          = {sb.sign, e[7:0], man_r[22:0]};
          r.flags[FLG_NX] = g | s;
        end
      end
    endcase
    return r;
  endfunction

  logic            issue;
  logic            pop;
  sband_t          iss_sb;
  sband_t          tl_sb;
  logic            tl_vld;
  logic            rnd_vld_q;
  sband_t          rnd_sb_q;
  logic [46:0]     rnd_p_q;
  res_t            res_d;
  res_t            head;
  logic [CW-1:0]   occ_q, occ_d;
  logic            rdy_q, rdy_d;
  logic [$clog2(FIFO_DEPTH):0] fifo_cnt;
  logic            unused_p47;

  // P never exceeds 2^46, so bit 47 carries no information.
  assign unused_p47 = mul_p[47];

  assign iss_sb = {iss_sign, iss_exp, iss_cls};
  assign issue  = iss_vld & rdy_q;

  // ---- issue -> side-band delay line (MULT_LAT stages) ----
  generate
    if (MULT_LAT == 0) begin : g_nodly
      assign tl_vld = issue;
      assign tl_sb  = iss_sb;
    end else begin : g_dly
      logic   vld_q [MULT_LAT];
      sband_t sb_q  [MULT_LAT];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < MULT_LAT; i++) vld_q[i] <= 1'b0;
        end else begin
          vld_q[0] <= issue;
          for (int i = 1; i < MULT_LAT; i++) vld_q[i] <= vld_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        sb_q[0] <= iss_sb;
        for (int i = 1; i < MULT_LAT; i++) sb_q[i] <= sb_q[i-1];
      end

      assign tl_vld = vld_q[MULT_LAT-1];
      assign tl_sb  = sb_q[MULT_LAT-1];
    end
  endgenerate

  // ---- round register: side-band meets the product ----
  always_ff @(posedge clk) begin
    if (tl_vld) begin
      rnd_sb_q <= tl_sb;
      rnd_p_q  <= mul_p[46:0];
    end
  end

  // occ tracks FIFO entries plus in-flight results; moving an item from the
  // pipeline into the FIFO leaves it unchanged, so only issue and pop count.
  always_comb begin
    occ_d = occ_q + CW'(issue) - CW'(pop);
    rdy_d = (occ_d < CW'(FIFO_DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rnd_vld_q <= 1'b0;
      occ_q     <= '0;
      rdy_q     <= 1'b0;
    end else begin
      rnd_vld_q <= tl_vld;
      occ_q     <= occ_d;
      rdy_q     <= rdy_d;
    end
  end

  // ---- round/pack -> output FIFO ----
  assign res_d = pack_result(rnd_sb_q, rnd_p_q);

  recip_out_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(res_t))
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (rnd_vld_q),
    .din_i   (res_d),
    .pop_i   (pop),
    .dout_o  (head),
    .count_o (fifo_cnt)
  );

  assign out_vld   = (fifo_cnt != '0);
  assign pop       = out_vld & out_rdy;
  assign out_data  = head.data;
  assign out_flags = head.flags;
  assign iss_rdy   = rdy_q;

endmodule

// File: tb/tb_flt_recip_pack.sv
module tb_flt_recip_pack;
  import recip_pkg::*;

  localparam int ML = 2;
  localparam int FD = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iss_vld;
  logic        iss_rdy;
  logic        iss_sign;
  logic [7:0]  iss_exp;
  logic [1:0]  iss_cls;
  logic [47:0] mul_p;
  logic        out_vld;
  logic        out_rdy;
  logic [31:0] out_data;
  logic [2:0]  out_flags;

  always #5 clk = ~clk;

  flt_recip_pack #(.MULT_LAT(ML), .FIFO_DEPTH(FD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .iss_vld   (iss_vld),
    .iss_rdy   (iss_rdy),
    .iss_sign  (iss_sign),
    .iss_exp   (iss_exp),
    .iss_cls   (iss_cls),
    .mul_p     (mul_p),
    .out_vld   (out_vld),
    .out_rdy   (out_rdy),
    .out_data  (out_data),
    .out_flags (out_flags)
  );

  typedef struct {
    logic [31:0] d;
    logic [2:0]  f;
  } exp_t;

  typedef struct {
    logic        s;
    logic [7:0]  e;
    logic [1:0]  c;
    logic [47:0] p;
    logic [31:0] d;
    logic [2:0]  f;
  } vec_t;

  int          n_pass = 0;
  int          n_chk  = 0;
  int          n_iss  = 0;
  int          edge_n = 0;
  logic [47:0] iss_p;
  logic [47:0] psched [int];
  exp_t        sbq [$];
  vec_t        vt [14];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
  endtask

  // Reference: value-level normalisation and round-half-even on the remainder.
  function automatic exp_t ref_model(input logic s, input logic [7:0] e8,
                                     input logic [1:0] c, input logic [47:0] p);
    exp_t            r;
    longint unsigned q, rem, half;
    int              sh, e;
    r.d = '0;
    r.f = '0;
    if (c == CLS_NAN)       r.d = 32'h7FC0_0000;
    else if (c == CLS_INF)  r.d = {s, 31'b0};
    else if (c == CLS_ZERO) begin
      r.d = {s, 8'hFF, 23'b0};
      r.f = 3'b100;
    end else begin
      sh   = p[46] ? 23 : 22;
      e    = 254 - int'(e8) - (p[46] ? 0 : 1);
      q    = longint'(p) >> sh;
      rem  = longint'(p) - (q << sh);
      half = 64'd1 << (sh - 1);
      if (e <= 0) begin
        r.d = {s, 31'b0};
        r.f = 3'b011;
      end else begin
        if (rem > half || (rem == half && q[0])) q++;
        if (q == (64'd1 << 24)) begin
          q = q >> 1;
          e++;
        end
        r.d = {s, 8'(e), 23'(q)};
        r.f = {2'b00, rem != 0};
      end
    end
    return r;
  endfunction

  // One clock: record an accepted issue, present the product due at this
  // edge, score a pop, then advance to 1ns after the edge.
  task automatic tick();
    exp_t ex;
    if (iss_vld && iss_rdy) begin
      psched[edge_n + ML] = iss_p;
      sbq.push_back(ref_model(iss_sign, iss_exp, iss_cls, iss_p));
      n_iss++;
    end
    mul_p = psched.exists(edge_n) ? psched[edge_n] : {16'($urandom), $urandom};
    if (out_vld && out_rdy) begin
      check("queue_nonempty", sbq.size() != 0, 1);
      if (sbq.size() != 0) begin
        ex = sbq.pop_front();
        check("sb_data", out_data, ex.d);
        check("sb_flags", out_flags, ex.f);
      end
    end
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic rand_op();
    int k;
    k        = $urandom_range(0, 15);
    iss_sign = 1'($urandom);
    iss_exp  = 8'($urandom_range(1, 254));
    iss_cls  = (k < 12) ? CLS_NORM : 2'(k - 11 > 3 ? 3 : k - 11);
    case ($urandom_range(0, 5))
      0:       iss_p = 48'h4000_0000_0000;
      1:       iss_p = {3'b001, 23'($urandom), 1'b1, 21'b0};
      2:       iss_p = {3'b001, {45{1'b1}}};
      default: iss_p = {3'b001, 13'($urandom), $urandom};
    endcase
  endtask

  task automatic run_vec(input int i);
    int          w;
    int          lat;
    logic [31:0] d;
    logic [2:0]  f;
    w = 0;
    while (!iss_rdy && w < 20) begin tick(); w++; end
    check($sformatf("v%0d_rdy", i), iss_rdy, 1);
    iss_sign = vt[i].s;
    iss_exp  = vt[i].e;
    iss_cls  = vt[i].c;
    iss_p    = vt[i].p;
    iss_vld  = 1'b1;
    tick();
    iss_vld  = 1'b0;
    lat = 0;
    while (!out_vld && lat < 20) begin tick(); lat++; end
    check($sformatf("v%0d_latency", i), lat, ML + 1);
    d = out_data;
    f = out_flags;
    check($sformatf("v%0d_data", i), d, vt[i].d);
    check($sformatf("v%0d_flags", i), f, vt[i].f);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int          acc0;
    int          stale;
    int          w;
    logic [31:0] hd;

    vt[0]  = '{1'b0, 8'd127, CLS_NORM, 48'h4000_0000_0000, 32'h3F80_0000, 3'b000};
    vt[1]  = '{1'b0, 8'd127, CLS_NORM, 48'h2AAA_AAAA_AAAA, 32'h3F2A_AAAB, 3'b001};
    vt[2]  = '{1'b1, 8'd0,   CLS_ZERO, 48'h1234_5678_9ABC, 32'hFF80_0000, 3'b100};
    vt[3]  = '{1'b0, 8'd200, CLS_INF,  48'h0000_0000_0000, 32'h0000_0000, 3'b000};
    vt[4]  = '{1'b1, 8'd90,  CLS_NAN,  48'h3FFF_0000_FFFF, 32'h7FC0_0000, 3'b000};
    vt[5]  = '{1'b1, 8'd254, CLS_NORM, 48'h2000_0000_0001, 32'h8000_0000, 3'b011};
    vt[6]  = '{1'b0, 8'd127, CLS_NORM, 48'h3FFF_FFFF_FFFF, 32'h3F80_0000, 3'b001};
    vt[7]  = '{1'b0, 8'd127, CLS_NORM, 48'h2000_0020_0000, 32'h3F00_0000, 3'b001};
    vt[8]  = '{1'b0, 8'd127, CLS_NORM, 48'h2000_0060_0000, 32'h3F00_0002, 3'b001};
    vt[9]  = '{1'b0, 8'd252, CLS_NORM, 48'h2000_0000_0000, 32'h0080_0000, 3'b000};
    vt[10] = '{1'b1, 8'd253, CLS_NORM, 48'h2000_0000_0000, 32'h8000_0000, 3'b011};
    vt[11] = '{1'b0, 8'd253, CLS_NORM, 48'h4000_0000_0000, 32'h0080_0000, 3'b000};
    vt[12] = '{1'b0, 8'd5,   CLS_ZERO, 48'h0000_0000_0000, 32'h7F80_0000, 3'b100};
    vt[13] = '{1'b1, 8'd77,  CLS_INF,  48'h2000_0000_0000, 32'h8000_0000, 3'b000};

    rst_n    = 1'b0;
    iss_vld  = 1'b0;
    iss_sign = 1'b0;
    iss_exp  = '0;
    iss_cls  = '0;
    iss_p    = '0;
    mul_p    = '0;
    out_rdy  = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_vld", out_vld, 0);
    check("rst_iss_rdy", iss_rdy, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_flags", out_flags, 0);
    rst_n = 1'b1;
    tick();
    check("rdy_after_reset", iss_rdy, 1);

    for (int i = 0; i < 14; i++) run_vec(i);

    // Back-pressure: consumer stalled, issue held high
    out_rdy = 1'b0;
    iss_vld = 1'b1;
    acc0    = n_iss;
    for (int i = 0; i < 10; i++) begin rand_op(); tick(); end
    iss_vld = 1'b0;
    check("bp_accepted", n_iss - acc0, 4);
    check("bp_iss_rdy_low", iss_rdy, 0);
    check("bp_out_vld", out_vld, 1);
    hd = out_data;
    tick();
    tick();
    check("bp_head_stable", out_data, hd);
    out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("bp_drain_vld%0d", i), out_vld, 1);
      tick();
      if (i == 0) check("bp_rdy_reassert", iss_rdy, 1);
    end
    check("bp_empty", out_vld, 0);

    // Reset with one queued and two in-flight items
    out_rdy = 1'b0;
    iss_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin rand_op(); tick(); end
    iss_vld = 1'b0;
    tick();
    check("pre_rst_vld", out_vld, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_vld", out_vld, 0);
    check("mid_rst_iss_rdy", iss_rdy, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_flags", out_flags, 0);
    sbq.delete();
    #2 rst_n = 1'b1;
    out_rdy = 1'b1;
    tick();
    check("post_rst_iss_rdy", iss_rdy, 1);
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_vld) stale++;
      tick();
    end
    check("post_rst_no_stale", stale, 0);

    // Randomised traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      rand_op();
      iss_vld = ($urandom_range(0, 9) < 7);
      out_rdy = ($urandom_range(0, 9) < 6);
      tick();
    end
    iss_vld = 1'b0;
    out_rdy = 1'b1;
    w = 0;
    while ((sbq.size() != 0) && w < 50) begin tick(); w++; end
    check("drain_queue_empty", sbq.size(), 0);
    check("drain_out_vld", out_vld, 0);
    check("final_iss_rdy", iss_rdy, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
